// File: rtl/click_mux_2_sync_if.sv
// ============================================================================
// Module      : click_mux_2_sync_if
// Description : Two-phase bundled-data channels for the click merge (B, C, sel -> A).
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface click_mux_2_sync_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  inb_req;
  logic                  inb_ack;
  logic [DATA_WIDTH-1:0] inb_data;
  logic                  inc_req;
  logic                  inc_ack;
  logic [DATA_WIDTH-1:0] inc_data;
  logic                  sel_req;
  logic                  sel_ack;
  logic                  sel_data;
  logic                  outa_req;
  logic                  outa_ack;
  logic [DATA_WIDTH-1:0] outa_data;

  modport slave (
    input  inb_req, inb_data, inc_req, inc_data, sel_req, sel_data, outa_ack,
    output inb_ack, inc_ack, sel_ack, outa_req, outa_data
  );

  modport master (
    output inb_req, inb_data, inc_req, inc_data, sel_req, sel_data, outa_ack,
    input  inb_ack, inc_ack, sel_ack, outa_req, outa_data
  );
endinterface

`default_nettype wire

// File: rtl/click_mux_2_sync.sv
// ============================================================================
// Module      : click_mux_2_sync
// Description : Clocked two-phase merge; one sel token then the selected B/C token
//               is forwarded on A. All incoming req/ack edges are synchronised.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module click_mux_2_sync #(
  parameter int   DATA_WIDTH     = 8,
  parameter int   SYNC_STAGES    = 2,
  parameter logic PHASE_INIT_A   = 1'b0,
  parameter logic PHASE_INIT_B   = 1'b0,
  parameter logic PHASE_INIT_C   = 1'b0,
  parameter logic PHASE_INIT_SEL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  click_mux_2_sync_if.slave    bus
);

  // Fewer than two flops would not be a synchroniser; clamp rather than break.
  localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_BUSY      = 2'd2
  } state_e;

  logic [NSYNC-1:0]      inb_sync_q;
  logic [NSYNC-1:0]      inc_sync_q;
  logic [NSYNC-1:0]      sel_sync_q;
  logic [NSYNC-1:0]      ack_sync_q;

  state_e                state_q;
  logic                  sel_q;
  logic                  outa_req_q;
  logic                  inb_ack_q;
  logic                  inc_ack_q;
  logic                  sel_ack_q;
  logic [DATA_WIDTH-1:0] outa_data_q;

  logic                  w_inb_pend;
  logic                  w_inc_pend;
  logic                  w_sel_pend;
  logic                  w_out_done;
  logic                  w_take_b;
  logic                  w_take_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inb_sync_q <= {NSYNC{PHASE_INIT_B}};
      inc_sync_q <= {NSYNC{PHASE_INIT_C}};
      sel_sync_q <= {NSYNC{PHASE_INIT_SEL}};
      ack_sync_q <= {NSYNC{PHASE_INIT_A}};
    end else begin
      inb_sync_q <= {inb_sync_q[NSYNC-2:0], bus.inb_req};
      inc_sync_q <= {inc_sync_q[NSYNC-2:0], bus.inc_req};
      sel_sync_q <= {sel_sync_q[NSYNC-2:0], bus.sel_req};
      ack_sync_q <= {ack_sync_q[NSYNC-2:0], bus.outa_ack};
    end
  end

  assign w_inb_pend = inb_sync_q[NSYNC-1] ^ inb_ack_q;
  assign w_inc_pend = inc_sync_q[NSYNC-1] ^ inc_ack_q;
  assign w_sel_pend = sel_sync_q[NSYNC-1] ^ sel_ack_q;
  assign w_out_done = (ack_sync_q[NSYNC-1] == outa_req_q);
  // The unselected channel is never sampled, even when it is pending.
  assign w_take_b   = sel_q & w_inb_pend;
  assign w_take_c   = ~sel_q & w_inc_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sel_q       <= 1'b0;
      outa_req_q  <= PHASE_INIT_A;
      inb_ack_q   <= PHASE_INIT_B;
      inc_ack_q   <= PHASE_INIT_C;
      sel_ack_q   <= PHASE_INIT_SEL;
      outa_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_sel_pend) begin
            sel_q   <= bus.sel_data;
            state_q <= S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          if (w_take_b) begin
            outa_data_q <= bus.inb_data;
            inb_ack_q   <= ~inb_ack_q;
            outa_req_q  <= ~outa_req_q;
            sel_ack_q   <= ~sel_ack_q;
            state_q     <= S_BUSY;
          end else if (w_take_c) begin
            outa_data_q <= bus.inc_data;
            inc_ack_q   <= ~inc_ack_q;
            outa_req_q  <= ~outa_req_q;
            sel_ack_q   <= ~sel_ack_q;
            state_q     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_out_done) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.outa_req  = outa_req_q;
  assign bus.outa_data = outa_data_q;
  assign bus.inb_ack   = inb_ack_q;
  assign bus.inc_ack   = inc_ack_q;
  assign bus.sel_ack   = sel_ack_q;

endmodule

`default_nettype wire

// File: tb/tb_click_mux_2_sync.sv
// ============================================================================
// Module      : tb_click_mux_2_sync
// Description : Self-checking bench for click_mux_2_sync (vector table, corner
//               sequences, randomized tokens against a queue-level model).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_click_mux_2_sync;

  localparam int DW = 8;
  localparam int SS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  click_mux_2_sync_if #(.DATA_WIDTH(DW)) bus  ();
  click_mux_2_sync_if #(.DATA_WIDTH(DW)) bus6 ();

  click_mux_2_sync #(
    .DATA_WIDTH(DW), .SYNC_STAGES(SS),
    .PHASE_INIT_A(1'b0), .PHASE_INIT_B(1'b0), .PHASE_INIT_C(1'b0), .PHASE_INIT_SEL(1'b0)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  click_mux_2_sync #(
    .DATA_WIDTH(DW), .SYNC_STAGES(SS),
    .PHASE_INIT_A(1'b1), .PHASE_INIT_B(1'b0), .PHASE_INIT_C(1'b0), .PHASE_INIT_SEL(1'b1)
  ) u_dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          sel;
    logic          sb;
    logic [DW-1:0] bd;
    logic          sc;
    logic [DW-1:0] cd;
    logic [DW-1:0] exp_d;
    logic          eb;
    logic          ec;
    logic          es;
    logic          eo;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Senders refuse to toggle a req whose previous token has not been acked.
  task automatic send_b(input logic [DW-1:0] d);
    check("proto_b", 32'(bus.inb_req ^ bus.inb_ack), 0);
    bus.inb_data = d;
    bus.inb_req  = ~bus.inb_req;
  endtask

  task automatic send_c(input logic [DW-1:0] d);
    check("proto_c", 32'(bus.inc_req ^ bus.inc_ack), 0);
    bus.inc_data = d;
    bus.inc_req  = ~bus.inc_req;
  endtask

  task automatic send_sel(input logic s);
    check("proto_sel", 32'(bus.sel_req ^ bus.sel_ack), 0);
    bus.sel_data = s;
    bus.sel_req  = ~bus.sel_req;
  endtask

  task automatic wait_out(input logic prev, input int budget, input string name);
    int n;
    n = 0;
    while (bus.outa_req === prev && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(bus.outa_req !== prev), 1);
  endtask

  task automatic ret_ack(input int hold);
    repeat (hold) @(negedge clk);
    bus.outa_ack = bus.outa_req;
    repeat (SS + 3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.inb_req  = 1'b0; bus.inb_data = '0;
    bus.inc_req  = 1'b0; bus.inc_data = '0;
    bus.sel_req  = 1'b0; bus.sel_data = 1'b0;
    bus.outa_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic          prev;
    logic          eb, ec, es, eo;
    int            n;
    int            nb, nc, ns;
    bit            bp, cp, s;
    logic [DW-1:0] bq, cq, expd;

    vt[0] = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 1'b1, 8'h5A, 1'b1, 8'h77, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1};
    vt[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    // Initial reset; the second instance starts with A and sel phases at 1.
    bus.inb_req  = 1'b0; bus.inb_data = '0;
    bus.inc_req  = 1'b0; bus.inc_data = '0;
    bus.sel_req  = 1'b0; bus.sel_data = 1'b0;
    bus.outa_ack = 1'b0;
    bus6.inb_req = 1'b0; bus6.inb_data = '0;
    bus6.inc_req = 1'b0; bus6.inc_data = '0;
    bus6.sel_req = 1'b1; bus6.sel_data = 1'b0;
    bus6.outa_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outa_req",  32'(bus.outa_req), 0);
    check("rst_outa_data", 32'(bus.outa_data), 0);
    check("rst_inb_ack",   32'(bus.inb_ack), 0);
    check("rst_inc_ack",   32'(bus.inc_ack), 0);
    check("rst_sel_ack",   32'(bus.sel_ack), 0);
    check("rst6_outa_req", 32'(bus6.outa_req), 1);
    check("rst6_sel_ack",  32'(bus6.sel_ack), 1);
    rst_n = 1'b1;
    @(negedge clk);

    // PHASE_INIT_SEL=1 with sel_req=1: no token until sel_req goes to 0.
    bus6.inb_data = 8'h6B;
    bus6.inb_req  = 1'b1;
    repeat (10) @(negedge clk);
    check("p6_hold_outa_req", 32'(bus6.outa_req), 1);
    check("p6_hold_inb_ack",  32'(bus6.inb_ack), 0);
    check("p6_hold_sel_ack",  32'(bus6.sel_ack), 1);
    bus6.sel_data = 1'b1;
    bus6.sel_req  = 1'b0;
    n = 0;
    while (bus6.outa_req === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("p6_outa_req",  32'(bus6.outa_req), 0);
    check("p6_outa_data", 32'(bus6.outa_data), 32'h6B);
    check("p6_inb_ack",   32'(bus6.inb_ack), 1);
    check("p6_sel_ack",   32'(bus6.sel_ack), 0);
    bus6.outa_ack = 1'b0;

    // Vector table, starting from the all-zero reset phases.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      prev = bus.outa_req;
      if (vt[i].sb) send_b(vt[i].bd);
      if (vt[i].sc) send_c(vt[i].cd);
      send_sel(vt[i].sel);
      wait_out(prev, 20, "vec");
      check("vec_data",     32'(bus.outa_data), 32'(vt[i].exp_d));
      check("vec_inb_ack",  32'(bus.inb_ack),   32'(vt[i].eb));
      check("vec_inc_ack",  32'(bus.inc_ack),   32'(vt[i].ec));
      check("vec_sel_ack",  32'(bus.sel_ack),   32'(vt[i].es));
      check("vec_outa_req", 32'(bus.outa_req),  32'(vt[i].eo));
      ret_ack(i % 3);
    end
    eb = 1'b0; ec = 1'b0; es = 1'b0; eo = 1'b0;

    // sel and C together: toggle lands on edge SS+2.
    @(negedge clk);
    send_c(8'h3C);
    send_sel(1'b0);
    repeat (SS + 1) @(negedge clk);
    check("lat2_early", 32'(bus.outa_req), 32'(eo));
    @(negedge clk);
    eo = ~eo; ec = ~ec; es = ~es;
    check("lat2_outa_req", 32'(bus.outa_req), 32'(eo));
    check("lat2_data",     32'(bus.outa_data), 32'h3C);
    check("lat2_inc_ack",  32'(bus.inc_ack), 32'(ec));
    check("lat2_inb_ack",  32'(bus.inb_ack), 32'(eb));
    ret_ack(0);

    // sel for B with only C pending: wait indefinitely, C untouched.
    @(negedge clk);
    send_sel(1'b1);
    send_c(8'h44);
    repeat (30) @(negedge clk);
    check("starve_outa_req", 32'(bus.outa_req), 32'(eo));
    check("starve_sel_ack",  32'(bus.sel_ack),  32'(es));
    check("starve_inc_ack",  32'(bus.inc_ack),  32'(ec));
    // B arrives last with sel already consumed: toggle on edge SS+1.
    send_b(8'h5B);
    repeat (SS) @(negedge clk);
    check("lat1_early", 32'(bus.outa_req), 32'(eo));
    @(negedge clk);
    eo = ~eo; eb = ~eb; es = ~es;
    check("lat1_outa_req", 32'(bus.outa_req), 32'(eo));
    check("lat1_data",     32'(bus.outa_data), 32'h5B);
    check("lat1_inb_ack",  32'(bus.inb_ack), 32'(eb));
    check("lat1_inc_ack",  32'(bus.inc_ack), 32'(ec));
    ret_ack(0);

    // Stalled receiver: outputs frozen while a second sel token waits.
    @(negedge clk);
    prev = bus.outa_req;
    send_sel(1'b0);
    wait_out(prev, 20, "stall1");
    eo = ~eo; ec = ~ec; es = ~es;
    check("stall1_data", 32'(bus.outa_data), 32'h44);
    send_sel(1'b1);
    send_b(8'h77);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("stall_outa_req", 32'(bus.outa_req),  32'(eo));
      check("stall_data",     32'(bus.outa_data), 32'h44);
      check("stall_sel_ack",  32'(bus.sel_ack),   32'(es));
    end
    prev = bus.outa_req;
    bus.outa_ack = bus.outa_req;
    wait_out(prev, 20, "stall2");
    eo = ~eo; eb = ~eb; es = ~es;
    check("stall2_data",    32'(bus.outa_data), 32'h77);
    check("stall2_sel_ack", 32'(bus.sel_ack),   32'(es));
    check("stall2_inb_ack", 32'(bus.inb_ack),   32'(eb));
    ret_ack(0);

    // Reset while BUSY with B pending; B is re-consumed afterwards.
    do_reset();
    send_c(8'h10);
    send_sel(1'b0);
    wait_out(1'b0, 20, "rb_first");
    check("rb_first_data", 32'(bus.outa_data), 32'h10);
    send_b(8'h99);
    repeat (2) @(negedge clk);
    rst_n        = 1'b0;
    bus.outa_ack = 1'b0;
    bus.sel_data = 1'b1;
    @(negedge clk);
    check("rb_outa_req",  32'(bus.outa_req), 0);
    check("rb_outa_data", 32'(bus.outa_data), 0);
    check("rb_inb_ack",   32'(bus.inb_ack), 0);
    check("rb_inc_ack",   32'(bus.inc_ack), 0);
    check("rb_sel_ack",   32'(bus.sel_ack), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_out(1'b0, 20, "rb_replay");
    check("rb_replay_data",    32'(bus.outa_data), 32'h99);
    check("rb_replay_inb_ack", 32'(bus.inb_ack), 1);
    check("rb_replay_inc_ack", 32'(bus.inc_ack), 0);
    check("rb_replay_sel_ack", 32'(bus.sel_ack), 1);
    ret_ack(0);

    // Randomized tokens against a per-channel pending/count model.
    do_reset();
    nb = 0; nc = 0; ns = 0;
    bp = 1'b0; cp = 1'b0;
    bq = '0; cq = '0;
    for (int t = 0; t < 40; t++) begin
      s = 1'($urandom_range(0, 1));
      @(negedge clk);
      prev = bus.outa_req;
      if (!bp && $urandom_range(0, 1) == 1) begin
        bq = DW'($urandom); send_b(bq); bp = 1'b1;
      end
      if (!cp && $urandom_range(0, 1) == 1) begin
        cq = DW'($urandom); send_c(cq); cp = 1'b1;
      end
      send_sel(s);
      if (s && !bp) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        bq = DW'($urandom); send_b(bq); bp = 1'b1;
      end else if (!s && !cp) begin
        repeat ($urandom_range(0, 5)) @(negedge clk);
        cq = DW'($urandom); send_c(cq); cp = 1'b1;
      end
      wait_out(prev, 40, "rnd");
      expd = s ? bq : cq;
      if (s) begin nb++; bp = 1'b0; end
      else   begin nc++; cp = 1'b0; end
      ns++;
      check("rnd_data",     32'(bus.outa_data), 32'(expd));
      check("rnd_inb_ack",  32'(bus.inb_ack),   32'(nb % 2));
      check("rnd_inc_ack",  32'(bus.inc_ack),   32'(nc % 2));
      check("rnd_sel_ack",  32'(bus.sel_ack),   32'(ns % 2));
      check("rnd_outa_req", 32'(bus.outa_req),  32'(ns % 2));
      ret_ack(int'($urandom_range(0, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
